// File: rtl/perf_mon_pkg.sv
// Shared definitions for the performance / halt monitor: state encodings,
// default instruction patterns and the halt-pattern helper.
package perf_mon_pkg;

  // Monitor state enumeration, kept as plain 2-bit encodings so older
  // tooling and register dumps can decode it without enum support.
  typedef logic [1:0] mon_state_t;

  localparam mon_state_t ST_IDLE    = 2'd0;
  localparam mon_state_t ST_RUN     = 2'd1;
  localparam mon_state_t ST_DONE    = 2'd2;
  localparam mon_state_t ST_TIMEOUT = 2'd3;

  // A `jal x0, 0` self-loop marks program end; an all-zero word is the bubble
  // the decoder sees once the fetch stage spins on that loop.
  localparam logic [31:0] DEFAULT_HALT_INSTR   = 32'h0000_006F;
  localparam logic [31:0] DEFAULT_BUBBLE_INSTR = 32'h0000_0000;

  // Run-length counter width; confirm counts are limited to 1..15.
  localparam int unsigned RUN_LEN_W = 4;

  function automatic logic is_halt_pattern(input logic [31:0] fetch_instr,
                                           input logic [31:0] decode_instr,
                                           input logic [31:0] halt_instr,
                                           input logic [31:0] bubble_instr);
    return (fetch_instr == halt_instr) && (decode_instr == bubble_instr);
  endfunction

endpackage

// File: rtl/perf_halt_monitor_if.sv
// Bus between a core-side observer and the perf/halt monitor: control
// requests, pipeline taps and event strobes in; state flags and counts out.
interface perf_halt_monitor_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned N_EVT = 4
);

  logic                     start;
  logic                     clear;
  logic [31:0]              fetch_instr;
  logic [31:0]              decode_instr;
  logic                     retire;
  logic [N_EVT-1:0]         evt;

  logic                     running;
  logic                     done;
  logic                     timed_out;
  logic [CNT_W-1:0]         cycles;
  logic [CNT_W-1:0]         retired_cnt;
  logic [N_EVT*CNT_W-1:0]   evt_cnt;

  // Side that drives the pipeline taps and reads the results.
  modport master (
    output start, clear, fetch_instr, decode_instr, retire, evt,
    input  running, done, timed_out, cycles, retired_cnt, evt_cnt
  );

  // The monitor itself.
  modport slave (
    input  start, clear, fetch_instr, decode_instr, retire, evt,
    output running, done, timed_out, cycles, retired_cnt, evt_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on rst or clr, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/perf_halt_monitor.sv
// Performance monitor that measures a program run: counts cycles, retired
// instructions and generic events from start until the core is seen spinning
// on its halt self-loop, or until a cycle budget is exhausted.
module perf_halt_monitor
  import perf_mon_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned N_EVT        = 4,
  parameter logic [31:0] HALT_INSTR   = DEFAULT_HALT_INSTR,
  parameter logic [31:0] BUBBLE_INSTR = DEFAULT_BUBBLE_INSTR,
  parameter int unsigned HALT_CONFIRM = 1,
  parameter int unsigned TIMEOUT      = 100000
) (
  input logic                clk,
  input logic                rst,
  perf_halt_monitor_if.slave bus
);

  localparam logic [RUN_LEN_W-1:0] CONFIRM_LEN = RUN_LEN_W'(HALT_CONFIRM);
  localparam logic [63:0]          TIMEOUT_VAL = 64'(TIMEOUT);

  mon_state_t           state_q, state_d;
  logic [RUN_LEN_W-1:0] run_len_q, run_len_d;
  logic                 running_q, done_q, timed_out_q;

  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 pattern;
  logic                 halt_hit;
  logic                 timeout_hit;

  logic [CNT_W-1:0]       cycles_q;
  logic [CNT_W-1:0]       retired_q;
  logic [CNT_W-1:0]       evt_q [N_EVT];
  logic [N_EVT*CNT_W-1:0] evt_flat;

  // A start is only honoured from IDLE and loses to a simultaneous clear.
  assign cnt_clr = (state_q == ST_IDLE) && bus.start && !bus.clear;

  // Counting happens only in RUN; a clear in RUN freezes the counts as-is.
  assign cnt_en  = (state_q == ST_RUN) && !bus.clear;

  assign pattern = is_halt_pattern(bus.fetch_instr, bus.decode_instr,
                                   HALT_INSTR, BUBBLE_INSTR);

  assign halt_hit = cnt_en && pattern && ((run_len_q + RUN_LEN_W'(1)) == CONFIRM_LEN);

  // Compare the post-increment cycle count so the limit is reached on the
  // same edge the counter lands on it.
  assign timeout_hit = cnt_en && ((64'(cycles_q) + 64'd1) == TIMEOUT_VAL);

  // Track consecutive halt-pattern cycles while running; any break restarts.
  always_comb begin
    run_len_d = '0;
    if (cnt_en && pattern && (run_len_q != '1)) begin
      run_len_d = run_len_q + RUN_LEN_W'(1);
    end
  end

  // Next-state selection; clear beats everything, halt beats timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cnt_clr) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
        end else if (halt_hit) begin
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_DONE, ST_TIMEOUT: begin
        if (bus.clear) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, run-length and registered state flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      run_len_q   <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_len_q   <= run_len_d;
      running_q   <= (state_d == ST_RUN);
      done_q      <= (state_d == ST_DONE);
      timed_out_q <= (state_d == ST_TIMEOUT);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycles (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_en),
    .q   (cycles_q)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_retired (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_en && bus.retire),
    .q   (retired_q)
  );

  for (genvar k = 0; k < N_EVT; k++) begin : g_evt
    sat_counter #(
      .W (CNT_W)
    ) u_evt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_en && bus.evt[k]),
      .q   (evt_q[k])
    );
  end

  // Pack event counters with event 0 in the least significant slice.
  always_comb begin
    evt_flat = '0;
    for (int k = 0; k < N_EVT; k++) begin
      evt_flat[k*CNT_W +: CNT_W] = evt_q[k];
    end
  end

  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.cycles      = cycles_q;
  assign bus.retired_cnt = retired_q;
  assign bus.evt_cnt     = evt_flat;

endmodule

// File: doc/perf_halt_monitor.md
PERF_HALT_MONITOR -- requirements
Module: perf_halt_monitor

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, width of every counter.
REQ-002 The block SHALL have parameter N_EVT, default 4, number of generic event counters.
REQ-003 The block SHALL have parameter HALT_INSTR, default 32'h0000006F, self-loop jump marking program end.
REQ-004 The block SHALL have parameter BUBBLE_INSTR, default 32'h00000000, decode-stage bubble encoding.
REQ-005 The block SHALL have parameter HALT_CONFIRM, default 1, consecutive halt-pattern cycles required (range 1..15).
REQ-006 The block SHALL have parameter TIMEOUT, default 100000, RUN-cycle limit.
REQ-007 The block SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-008 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 The block SHALL have port start, input, 1, one-cycle request to begin measurement.
REQ-010 The block SHALL have port clear, input, 1, abort/acknowledge, returns to IDLE.
REQ-011 The block SHALL have port fetch_instr, input, 32, fetch-stage instruction_out.
REQ-012 The block SHALL have port decode_instr, input, 32, decode-stage instruction.
REQ-013 The block SHALL have port retire, input, 1, one instruction retired this cycle.
REQ-014 The block SHALL have port evt, input, N_EVT, per-cycle event strobes (stalls, flushes, misses).
REQ-015 The block SHALL have ports running, done, timed_out, output, 1 each, state flags.
REQ-016 The block SHALL have ports cycles and retired_cnt, output, CNT_W each, cycle and retired-instruction counts.
REQ-017 The block SHALL have port evt_cnt, output, N_EVT*CNT_W, event counts packed with event 0 in LSBs.

Function
REQ-018 States SHALL be IDLE, RUN, DONE, TIMEOUT; running=RUN, done=DONE, timed_out=TIMEOUT, all registered.
REQ-019 IDLE with start=1 SHALL zero all counters and enter RUN on the next edge; start outside IDLE SHALL be ignored.
REQ-020 In RUN, cycles SHALL increment every cycle, including the cycle in which halt is detected.
REQ-021 In RUN, retired_cnt and evt_cnt[k] SHALL increment in the same cycle their strobe is high.
REQ-022 Halt pattern: fetch_instr==HALT_INSTR and decode_instr==BUBBLE_INSTR in the same cycle.
REQ-023 An internal run-length counter SHALL count consecutive halt-pattern cycles in RUN and SHALL reset to 0 on any non-pattern cycle.
REQ-024 When the run-length reaches HALT_CONFIRM, the FSM SHALL enter DONE on that edge, with counters including that cycle.
REQ-025 When cycles reaches TIMEOUT in RUN, the FSM SHALL enter TIMEOUT on that edge.
REQ-026 If halt and timeout occur in the same cycle, DONE SHALL win.
REQ-027 Counters SHALL saturate at all-ones and never wrap.
REQ-028 In DONE and TIMEOUT, all counters SHALL hold and be stable for readout.
REQ-029 clear in any state SHALL enter IDLE on the next edge with counters held; clear SHALL have priority over start, halt and timeout.
REQ-030 Strobes and patterns in IDLE, DONE or TIMEOUT SHALL have no effect.

Reset
REQ-031 rst SHALL force IDLE, all counters 0, run-length 0, and running/done/timed_out 0 on the next edge.
REQ-032 rst SHALL override clear, start and every in-progress measurement, including mid-RUN.

Structure
REQ-033 The state enum and default HALT_INSTR/BUBBLE_INSTR constants SHALL live in shared package perf_mon_pkg.
REQ-034 One sub-module sat_counter (parameter W; ports clr, inc, q; saturating) SHALL be instantiated for cycles, retired_cnt and each evt_cnt.

Verification
REQ-035 start, 10 non-halt cycles, then the halt pattern with HALT_CONFIRM=1 -> next cycle done=1, cycles=11.
REQ-036 HALT_CONFIRM=3, pattern 2 cycles, 1 gap, 3 cycles -> done only after the third consecutive pattern cycle; the gap does not trigger.
REQ-037 TIMEOUT=20, no halt -> timed_out=1, cycles=20, held for 5 further cycles; with halt on cycle 20 -> done=1 instead.
REQ-038 CNT_W=4, retire high 20 cycles -> retired_cnt=15 with no wrap; evt[2] strobed 3 times -> evt_cnt slice 2 = 3, other slices 0.
REQ-039 rst pulse mid-RUN at cycles=7 -> IDLE, all outputs 0; a subsequent start counts from 0.
REQ-040 clear and start asserted together in IDLE -> stays IDLE; clear in DONE -> IDLE with counts retained.
